// File: rtl/fc_layer_sequencer.sv
// Frame sequencer for the combinational fully-connected layer.
// Loads one activation per handshake into a vector that feeds every neuron,
// waits a fixed settle interval, snapshots the neuron outputs and streams
// them out one per handshake. A new frame can load while the previous one drains.
module fc_layer_sequencer #(
    parameter int WIDTH   = 8,
    parameter int IN      = 400,
    parameter int N_OUT   = 10,
    parameter int Z_WIDTH = 22,
    parameter int SETTLE  = 2,
    localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_last,
    output logic [IN*WIDTH-1:0]      x_bus,
    input  logic [N_OUT*Z_WIDTH-1:0] z_bus,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [Z_WIDTH-1:0]       out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic                     busy,
    output logic                     frame_err
);

    localparam int CNT_W = (IN > 1) ? $clog2(IN) : 1;
    localparam int SET_W = $clog2(SETTLE + 1);

    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(IN - 1);
    localparam logic [SET_W-1:0] SETTLE_END = SET_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_OUT - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_SNAP
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]   load_cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic [WIDTH-1:0]   buffer   [IN];
    logic [Z_WIDTH-1:0] snap_reg [N_OUT];
    logic               drain_active;

    logic accept;
    logic last_beat;
    logic early_last;
    logic out_fire;
    logic drain_done;
    logic snap_go;

    assign accept     = in_valid && in_ready;
    assign last_beat  = (load_cnt == LAST_BEAT);
    assign early_last = accept && in_last && !last_beat;
    assign out_fire   = out_valid && out_ready;
    assign drain_done = out_fire && out_last;

    // Load FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Load FSM next state, input handshake and snapshot trigger
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        snap_go    = 1'b0;
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_END) begin
                    state_next = ST_SNAP;
                end
            end
            ST_SNAP: begin
                // snapshot may overwrite the registers in the same cycle the old drain finishes
                if (!drain_active || drain_done) begin
                    snap_go    = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    // Beat counter: clears on the final beat or when an early in_last aborts the frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_cnt <= '0;
        end else if (accept) begin
            if (last_beat || in_last) begin
                load_cnt <= '0;
            end else begin
                load_cnt <= load_cnt + 1'b1;
            end
        end
    end

    // Settle timer counts the cycles spent waiting for the combinational layer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (state == ST_SETTLE && settle_cnt != SETTLE_END) begin
            settle_cnt <= settle_cnt + 1'b1;
        end else begin
            settle_cnt <= '0;
        end
    end

    // Activation buffer; the aborting beat of a bad frame is not stored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < IN; k++) begin
                buffer[k] <= '0;
            end
        end else if (accept && !early_last) begin
            buffer[load_cnt] <= in_data;
        end
    end

    // One-cycle error pulse following an early in_last
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= early_last;
        end
    end

    // Snapshot of all neuron outputs, decoupling the drain from the next load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < N_OUT; j++) begin
                snap_reg[j] <= '0;
            end
        end else if (snap_go) begin
            for (int j = 0; j < N_OUT; j++) begin
                snap_reg[j] <= z_bus[j*Z_WIDTH +: Z_WIDTH];
            end
        end
    end

    // Drain engine: walks the snapshot one result per output handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drain_active <= 1'b0;
            out_idx      <= '0;
        end else if (snap_go) begin
            drain_active <= 1'b1;
            out_idx      <= '0;
        end else if (drain_done) begin
            drain_active <= 1'b0;
            out_idx      <= '0;
        end else if (out_fire) begin
            out_idx <= out_idx + 1'b1;
        end
    end

    for (genvar k = 0; k < IN; k++) begin : g_xbus
        assign x_bus[k*WIDTH +: WIDTH] = buffer[k];
    end

    assign out_valid = drain_active;
    assign out_data  = snap_reg[out_idx];
    assign out_last  = drain_active && (out_idx == LAST_IDX);
    assign busy      = (state != ST_LOAD) || (load_cnt != '0) || drain_active;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Self-checking bench: a small instance (IN=4, N_OUT=3) for directed frame,
// stall, error, back-to-back and reset scenarios, plus a default-size instance
// checked against a reference weighted-sum model.
module tb_fc_layer_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    int tests_run = 0;
    int tests_failed = 0;
    int hs_count = 0;

    // small instance signals
    logic        s_in_valid, s_in_ready, s_in_last;
    logic [7:0]  s_in_data;
    logic [31:0] s_x_bus;
    logic [65:0] s_z_bus;
    logic        s_out_valid, s_out_ready, s_out_last, s_busy, s_frame_err;
    logic [21:0] s_out_data;
    logic [1:0]  s_out_idx;

    // default instance signals
    logic         d_in_valid, d_in_ready, d_in_last;
    logic [7:0]   d_in_data;
    logic [3199:0] d_x_bus;
    logic [219:0] d_z_bus;
    logic         d_out_valid, d_out_ready, d_out_last, d_busy, d_frame_err;
    logic [21:0]  d_out_data;
    logic [3:0]   d_out_idx;

    logic [21:0] exp_data [$];
    int          exp_idx  [$];

    fc_layer_sequencer #(.WIDTH(8), .IN(4), .N_OUT(3), .Z_WIDTH(22), .SETTLE(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
        .x_bus(s_x_bus), .z_bus(s_z_bus),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_idx(s_out_idx), .out_last(s_out_last), .busy(s_busy), .frame_err(s_frame_err)
    );

    fc_layer_sequencer dut_d (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data), .in_last(d_in_last),
        .x_bus(d_x_bus), .z_bus(d_z_bus),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
        .out_idx(d_out_idx), .out_last(d_out_last), .busy(d_busy), .frame_err(d_frame_err)
    );

    always #5 clk = ~clk;

    // small neuron layer: z_j = (j+1) * sum of activations
    function automatic logic [65:0] neuron_s(input logic [31:0] x);
        logic [65:0] r;
        int sum;
        sum = int'(x[7:0]) + int'(x[15:8]) + int'(x[23:16]) + int'(x[31:24]);
        r = '0;
        for (int j = 0; j < 3; j++) r[j*22 +: 22] = 22'((j + 1) * sum);
        return r;
    endfunction

    function automatic int weight(input int j, input int k);
        return ((j + k) % 5) + 1;
    endfunction

    // default neuron layer: weighted sum with small fixed weights
    function automatic logic [219:0] neuron_d(input logic [3199:0] x);
        logic [219:0] r;
        int acc;
        r = '0;
        for (int j = 0; j < 10; j++) begin
            acc = 0;
            for (int k = 0; k < 400; k++) acc += int'(x[k*8 +: 8]) * weight(j, k);
            r[j*22 +: 22] = 22'(acc);
        end
        return r;
    endfunction

    assign s_z_bus = neuron_s(s_x_bus);
    assign d_z_bus = neuron_d(d_x_bus);

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests_run++;
        if (obs !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard on the small instance: every output handshake must match the queue head
    always @(negedge clk) begin
        if (s_out_valid && s_out_ready) begin
            hs_count++;
            if (exp_data.size() == 0) begin
                checkOutput("spurious_hs", 64'd1, 64'd0);
            end else begin
                logic [21:0] e;
                int ei;
                e  = exp_data.pop_front();
                ei = exp_idx.pop_front();
                checkOutput("drain_data", 64'(s_out_data), 64'(e));
                checkOutput("drain_idx", 64'(s_out_idx), 64'(ei));
                checkOutput("drain_last", 64'(s_out_last), 64'(ei == 2));
            end
        end
    end

    task automatic push_frame(input int sum);
        for (int j = 0; j < 3; j++) begin
            exp_data.push_back(22'((j + 1) * sum));
            exp_idx.push_back(j);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic l);
        int n;
        s_in_valid = 1'b1;
        s_in_data  = d;
        s_in_last  = l;
        n = 0;
        while (!s_in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!s_in_ready) checkOutput("in_ready_timeout", 64'd0, 64'd1);
        tick();
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        applyStimulus(a, 1'b0);
        applyStimulus(b, 1'b0);
        applyStimulus(c, 1'b0);
        applyStimulus(d, 1'b1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!s_out_valid && n < 50) begin
            tick();
            n++;
        end
        checkOutput(tag, 64'(s_out_valid), 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((s_out_valid || exp_data.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        checkOutput(tag, 64'(exp_data.size()), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        checkOutput({tag, "_in_ready"}, 64'(s_in_ready), 64'd1);
        checkOutput({tag, "_out_valid"}, 64'(s_out_valid), 64'd0);
        checkOutput({tag, "_out_data"}, 64'(s_out_data), 64'd0);
        checkOutput({tag, "_out_idx"}, 64'(s_out_idx), 64'd0);
        checkOutput({tag, "_out_last"}, 64'(s_out_last), 64'd0);
        checkOutput({tag, "_busy"}, 64'(s_busy), 64'd0);
        checkOutput({tag, "_frame_err"}, 64'(s_frame_err), 64'd0);
        checkOutput({tag, "_x_bus"}, 64'(s_x_bus), 64'd0);
    endtask

    // watchdog so the run always terminates
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  act   [400];
        int          exp_z [10];
        logic [3:0]  pat;
        logic [21:0] pd;
        logic [1:0]  pi;
        int          hs0;
        int          n;

        rst_n = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_in_last = 1'b0; s_out_ready = 1'b1;
        d_in_valid = 1'b0; d_in_data = '0; d_in_last = 1'b0; d_out_ready = 1'b1;
        tick();
        tick();
        check_reset_state("rst_hold");
        rst_n = 1'b1;
        tick();
        check_reset_state("rst_rel");

        // frame 1,2,3,4 with out_ready high: exact latency and full throughput
        push_frame(10);
        send_frame(8'd1, 8'd2, 8'd3, 8'd4);
        checkOutput("f1_x_bus", 64'(s_x_bus), 64'h04030201);
        checkOutput("f1_in_ready_E", 64'(s_in_ready), 64'd0);
        checkOutput("f1_busy", 64'(s_busy), 64'd1);
        tick();
        checkOutput("f1_valid_E1", 64'(s_out_valid), 64'd0);
        tick();
        checkOutput("f1_valid_E2", 64'(s_out_valid), 64'd0);
        checkOutput("f1_in_ready_E2", 64'(s_in_ready), 64'd0);
        tick();
        checkOutput("f1_valid_E3", 64'(s_out_valid), 64'd1);
        checkOutput("f1_in_ready_E3", 64'(s_in_ready), 64'd1);
        checkOutput("f1_data0", 64'(s_out_data), 64'd10);
        tick();
        checkOutput("f1_data1", 64'(s_out_data), 64'd20);
        tick();
        checkOutput("f1_data2", 64'(s_out_data), 64'd30);
        checkOutput("f1_last2", 64'(s_out_last), 64'd1);
        tick();
        checkOutput("f1_valid_end", 64'(s_out_valid), 64'd0);
        checkOutput("f1_busy_end", 64'(s_busy), 64'd0);
        checkOutput("f1_queue", 64'(exp_data.size()), 64'd0);

        // stall pattern 1,0,0,1: outputs hold during stalls, exactly three handshakes
        s_out_ready = 1'b0;
        push_frame(20);
        send_frame(8'd2, 8'd4, 8'd6, 8'd8);
        wait_valid("f2_valid");
        pat = 4'b1001;
        hs0 = hs_count;
        n = 0;
        while (s_out_valid && n < 20) begin
            s_out_ready = pat[n % 4];
            pd = s_out_data;
            pi = s_out_idx;
            tick();
            if (!pat[n % 4]) begin
                checkOutput("f2_hold_data", 64'(s_out_data), 64'(pd));
                checkOutput("f2_hold_idx", 64'(s_out_idx), 64'(pi));
            end
            n++;
        end
        checkOutput("f2_hs_count", 64'(hs_count - hs0), 64'd3);
        checkOutput("f2_queue", 64'(exp_data.size()), 64'd0);
        s_out_ready = 1'b1;

        // early in_last on beat 2: error pulse, frame discarded, aborting beat not stored
        applyStimulus(8'd5, 1'b0);
        applyStimulus(8'd6, 1'b1);
        checkOutput("err_pulse", 64'(s_frame_err), 64'd1);
        checkOutput("err_x_bus", 64'(s_x_bus), 64'h08060405);
        checkOutput("err_busy", 64'(s_busy), 64'd0);
        checkOutput("err_in_ready", 64'(s_in_ready), 64'd1);
        tick();
        checkOutput("err_pulse_end", 64'(s_frame_err), 64'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("err_no_valid", 64'(s_out_valid), 64'd0);
            tick();
        end
        push_frame(4);
        send_frame(8'd1, 8'd1, 8'd1, 8'd1);
        wait_drain("err_next_frame");

        // back-to-back frames with the first drain stalled
        s_out_ready = 1'b0;
        hs0 = hs_count;
        push_frame(10);
        push_frame(16);
        send_frame(8'd1, 8'd2, 8'd3, 8'd4);
        send_frame(8'd4, 8'd4, 8'd4, 8'd4);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("b2b_in_ready", 64'(s_in_ready), 64'd0);
        checkOutput("b2b_busy", 64'(s_busy), 64'd1);
        checkOutput("b2b_valid", 64'(s_out_valid), 64'd1);
        checkOutput("b2b_head_data", 64'(s_out_data), 64'd10);
        checkOutput("b2b_head_idx", 64'(s_out_idx), 64'd0);
        checkOutput("b2b_x_bus", 64'(s_x_bus), 64'h04040404);
        s_out_ready = 1'b1;
        wait_drain("b2b_drain");
        checkOutput("b2b_hs_count", 64'(hs_count - hs0), 64'd6);

        // reset mid-load, then mid-drain, then a clean frame
        s_out_ready = 1'b0;
        applyStimulus(8'd1, 1'b0);
        applyStimulus(8'd2, 1'b0);
        checkOutput("rst_mid_busy", 64'(s_busy), 64'd1);
        rst_n = 1'b0;
        tick();
        check_reset_state("rst_mid_load");
        rst_n = 1'b1;
        push_frame(12);
        send_frame(8'd3, 8'd3, 8'd3, 8'd3);
        wait_valid("rst_frame_valid");
        checkOutput("rst_frame_data", 64'(s_out_data), 64'd12);
        rst_n = 1'b0;
        tick();
        check_reset_state("rst_mid_drain");
        exp_data.delete();
        exp_idx.delete();
        rst_n = 1'b1;
        s_out_ready = 1'b1;
        push_frame(10);
        send_frame(8'd1, 8'd2, 8'd3, 8'd4);
        wait_drain("rst_after_frame");

        // default-size instance: random frame against the weighted-sum reference
        for (int k = 0; k < 400; k++) act[k] = 8'($urandom_range(0, 255));
        for (int j = 0; j < 10; j++) begin
            exp_z[j] = 0;
            for (int k = 0; k < 400; k++) exp_z[j] += int'(act[k]) * weight(j, k);
        end
        for (int k = 0; k < 400; k++) begin
            d_in_valid = 1'b1;
            d_in_data  = act[k];
            d_in_last  = (k == 399);
            tick();
        end
        d_in_valid = 1'b0;
        d_in_last  = 1'b0;
        n = 0;
        while (!d_out_valid && n < 50) begin
            tick();
            n++;
        end
        checkOutput("dflt_valid", 64'(d_out_valid), 64'd1);
        checkOutput("dflt_x0", 64'(d_x_bus[7:0]), 64'(act[0]));
        checkOutput("dflt_x399", 64'(d_x_bus[3199:3192]), 64'(act[399]));
        for (int j = 0; j < 10; j++) begin
            checkOutput("dflt_data", 64'(d_out_data), 64'(22'(exp_z[j])));
            checkOutput("dflt_idx", 64'(d_out_idx), 64'(j));
            checkOutput("dflt_last", 64'(d_out_last), 64'(j == 9));
            tick();
        end
        checkOutput("dflt_valid_end", 64'(d_out_valid), 64'd0);
        checkOutput("dflt_busy_end", 64'(d_busy), 64'd0);
        checkOutput("dflt_frame_err", 64'(d_frame_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
